sort4_serializer: RTL and testbench

- Downstream stage of the 4-input sorting network.
- Captures each sorted 4-element result frame (data + labels) when the sorter's y_valid pulses, and buffers it in a small frame FIFO.
- Replays the frame as a serial valid/ready stream, one element per accepted beat, in sorted order (index 0 first), with index and last markers.
- Absorbs the sorter's lack of back-pressure; frames arriving with no free slot are dropped and flagged.

---
 rtl/sort4_serializer_pkg.sv | 20 ++
 rtl/sort4_serializer_fifo.sv | 61 ++++++
 rtl/sort4_serializer.sv | 93 +++++++++
 tb/tb_sort4_serializer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sort4_serializer_pkg.sv
// Shared sorter definitions: default element widths, frame size and a width helper.
package sort4_serializer_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_LABEL_WIDTH = 1;
    localparam int FRAME_SIZE      = 4;
    localparam int IDX_W           = 2;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sort4_serializer_fifo.sv
// Register FIFO holding whole sorted frames; storage is intentionally left unreset.
module sort_frame_fifo
    import sort4_serializer_pkg::*;
#(
    parameter int  WIDTH = 36,
    parameter int  DEPTH = 2,
    localparam int PTR_W = clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so pointer wrap is plain overflow.
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/sort4_serializer.sv
// Buffers sorted 4-element frames and replays them as a valid/ready element stream.
module sort4_serializer
    import sort4_serializer_pkg::*;
#(
    parameter int  DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int  LABEL_WIDTH = DEF_LABEL_WIDTH,
    parameter int  FRAME_DEPTH = 2,
    localparam int CNT_W       = clog2(FRAME_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [DATA_WIDTH-1:0]  in_data_0,
    input  logic [DATA_WIDTH-1:0]  in_data_1,
    input  logic [DATA_WIDTH-1:0]  in_data_2,
    input  logic [DATA_WIDTH-1:0]  in_data_3,
    input  logic [LABEL_WIDTH-1:0] in_label_0,
    input  logic [LABEL_WIDTH-1:0] in_label_1,
    input  logic [LABEL_WIDTH-1:0] in_label_2,
    input  logic [LABEL_WIDTH-1:0] in_label_3,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [LABEL_WIDTH-1:0] out_label,
    output logic [IDX_W-1:0]       out_index,
    output logic                   out_last,
    output logic                   overflow,
    output logic [CNT_W-1:0]       frame_count
);

    localparam int EL_W = DATA_WIDTH + LABEL_WIDTH;

    logic [FRAME_SIZE-1:0][EL_W-1:0] in_frame, head_frame;
    logic [EL_W-1:0]                 head_el;
    logic [IDX_W-1:0]                index_q, index_d;
    logic                            overflow_q, overflow_d;
    logic                            fifo_full, fifo_empty;
    logic                            xfer, last_pop, push;

    assign in_frame[0] = {in_data_0, in_label_0};
    assign in_frame[1] = {in_data_1, in_label_1};
    assign in_frame[2] = {in_data_2, in_label_2};
    assign in_frame[3] = {in_data_3, in_label_3};

    sort_frame_fifo #(
        .WIDTH (FRAME_SIZE * EL_W),
        .DEPTH (FRAME_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (last_pop),
        .wdata (in_frame),
        .rdata (head_frame),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (frame_count)
    );

    always_comb begin
        out_valid  = !fifo_empty;
        xfer       = out_valid && out_ready;
        last_pop   = xfer && (index_q == IDX_W'(FRAME_SIZE - 1));
        // A full FIFO still takes a frame if the head frame leaves this cycle.
        push       = in_valid && (!fifo_full || last_pop);
        index_d    = xfer ? index_q + IDX_W'(1) : index_q;
        overflow_d = overflow_q || (in_valid && fifo_full && !last_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            index_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            index_q    <= index_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        head_el   = head_frame[index_q];
        out_data  = '0;
        out_label = '0;
        if (out_valid) begin
            out_data  = head_el[EL_W-1:LABEL_WIDTH];
            out_label = head_el[LABEL_WIDTH-1:0];
        end
        out_index = index_q;
        out_last  = out_valid && (index_q == IDX_W'(FRAME_SIZE - 1));
        overflow  = overflow_q;
    end

endmodule

// File: tb/tb_sort4_serializer.sv
// Randomized + directed bench: frame-level reference model feeds a beat scoreboard.
module tb_sort4_serializer;

    localparam int FD = 2;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [3:0][7:0]  fd;
    logic [3:0]       fl;
    logic             out_valid, out_ready, out_last, overflow;
    logic [7:0]       out_data;
    logic [0:0]       out_label;
    logic [1:0]       out_index;
    logic [1:0]       frame_count;

    sort4_serializer #(.DATA_WIDTH(8), .LABEL_WIDTH(1), .FRAME_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in_data_0(fd[0]), .in_data_1(fd[1]), .in_data_2(fd[2]), .in_data_3(fd[3]),
        .in_label_0(fl[0]), .in_label_1(fl[1]), .in_label_2(fl[2]), .in_label_3(fl[3]),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_label(out_label), .out_index(out_index), .out_last(out_last),
        .overflow(overflow), .frame_count(frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [7:0] d; logic l; logic [1:0] idx; } beat_t;
    beat_t exp_q[$];

    int tests = 0;
    int fails = 0;

    // Reference model: frames held and elements already sent from the head frame.
    int m_frames = 0;
    int m_pos    = 0;
    bit m_ovf    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after posedge; both checkers sample at negedge.
    task automatic step(input bit v, input bit rdy, input bit r,
                        input logic [3:0][7:0] d, input logic [3:0] l);
        rst = r; in_valid = v; out_ready = rdy; fd = d; fl = l;
        @(posedge clk); #1;
    endtask

    task automatic idle(input bit rdy, input int n);
        for (int i = 0; i < n; i++) step(1'b0, rdy, 1'b1, '0, '0);
    endtask

    always @(negedge clk) begin : model
        bit pop, last, acc;
        chk("out_valid", out_valid, m_frames > 0);
        chk("frame_count", frame_count, m_frames);
        chk("overflow", overflow, m_ovf);
        if (m_frames == 0) begin
            chk("idle_data", {out_data, out_label, out_last, out_index}, 0);
        end else begin
            chk("index", out_index, m_pos);
        end
        if (rst !== 1'b1) begin
            m_frames = 0; m_pos = 0; m_ovf = 0;
            exp_q.delete();
        end else begin
            pop  = (m_frames > 0) && out_ready;
            last = pop && (m_pos == 3);
            acc  = in_valid && (m_frames < FD || last);
            if (in_valid && !acc) m_ovf = 1;
            if (acc) begin
                for (int i = 0; i < 4; i++) exp_q.push_back('{fd[i], fl[i], 2'(i)});
            end
            if (pop) m_pos = (m_pos + 1) % 4;
            m_frames = m_frames - (last ? 1 : 0) + (acc ? 1 : 0);
        end
    end

    bit         prev_stall = 0;
    logic [7:0] h_d;
    logic       h_l, h_last;
    logic [1:0] h_idx;

    always @(negedge clk) begin : monitor
        beat_t e;
        if (rst !== 1'b1) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_hold", {out_data, out_label, out_index, out_last},
                    {h_d, h_l, h_idx, h_last});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", out_data, e.d);
                    chk("beat_label", out_label, e.l);
                    chk("beat_index", out_index, e.idx);
                    chk("beat_last", out_last, e.idx == 2'd3);
                end
            end
            prev_stall = out_valid && !out_ready;
            h_d = out_data; h_l = out_label; h_idx = out_index; h_last = out_last;
        end
    end

    initial begin
        logic [3:0][7:0] fa, fb, fc, fr;
        logic [3:0]      la, lb, lc, lr;
        bit              rr, vv, ss;
        int              guard;
        fa = {8'd12, 8'd9, 8'd5, 8'd3}; la = 4'b0101;
        fb = {8'd200, 8'd100, 8'd50, 8'd1}; lb = 4'b1100;
        fc = {8'd77, 8'd66, 8'd55, 8'd44}; lc = 4'b0011;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; fd = '0; fl = '0;
        @(posedge clk); #1;

        // Reset then idle
        step(1'b0, 1'b1, 1'b0, '0, '0);
        step(1'b0, 1'b1, 1'b0, '0, '0);
        idle(1'b1, 3);

        // Single frame
        step(1'b1, 1'b1, 1'b1, fa, la);
        idle(1'b1, 6);

        // Back-pressure pattern 1,0,0,1,1,0,1
        step(1'b1, 1'b0, 1'b1, fa, la);
        foreach (rr_pat[i]) step(1'b0, rr_pat[i], 1'b1, '0, '0);
        idle(1'b1, 4);

        // Overflow: A, B kept, C dropped
        step(1'b1, 1'b0, 1'b1, fa, la);
        step(1'b1, 1'b0, 1'b1, fb, lb);
        step(1'b1, 1'b0, 1'b1, fc, lc);
        idle(1'b0, 2);
        idle(1'b1, 10);
        step(1'b0, 1'b1, 1'b0, '0, '0);

        // Full FIFO with head at index 3: push and last-beat pop together
        step(1'b1, 1'b0, 1'b1, fa, la);
        step(1'b1, 1'b0, 1'b1, fb, lb);
        idle(1'b1, 3);
        step(1'b1, 1'b1, 1'b1, fc, lc);
        idle(1'b1, 12);

        // Reset after two beats, then a fresh frame
        step(1'b1, 1'b1, 1'b1, fa, la);
        idle(1'b1, 2);
        step(1'b0, 1'b1, 1'b0, '0, '0);
        step(1'b1, 1'b1, 1'b1, fb, lb);
        idle(1'b1, 6);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 4; i++) fr[i] = 8'($urandom);
            lr = 4'($urandom);
            vv = ($urandom_range(0, 99) < 30);
            rr = ($urandom_range(0, 99) < 70);
            ss = ($urandom_range(0, 299) != 0);
            step(vv, rr, ss, fr, lr);
        end

        guard = 0;
        while (m_frames > 0 && guard < 50) begin
            step(1'b0, 1'b1, 1'b1, '0, '0);
            guard++;
        end
        chk("drain_done", m_frames, 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    bit rr_pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

endmodule
